// File: rtl/maxpool2x2.sv
// 2x2 stride-2 max-pooling stage on a strobe-qualified raster pixel stream.
// Keeps half a row of horizontal pair maxima; one registered output per window.
`ifndef DW
`define DW 16
`endif

module maxpool2x2 #(
    parameter int FW = 8,
    parameter int FH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic signed [`DW-1:0] i_data,
    input  logic                  i_flush,
    output logic                  o_en,
    output logic signed [`DW-1:0] o_data,
    output logic                  o_frame_done
);

    localparam int CW = (FW > 2) ? $clog2(FW) : 1;
    localparam int RW = (FH > 2) ? $clog2(FH) : 1;
    localparam int LW = (FW > 2) ? $clog2(FW / 2) : 1;

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic signed [`DW-1:0] pair_q;
    logic signed [`DW-1:0] lb [FW/2];

    logic [LW-1:0]         lb_idx;
    logic signed [`DW-1:0] lb_rd;
    logic signed [`DW-1:0] hmax;
    logic signed [`DW-1:0] vmax;
    logic                  last_col;
    logic                  last_row;

    // Window maxima: ties keep the earlier value, all compares are signed.
    always_comb begin
        lb_idx   = LW'(col >> 1);
        lb_rd    = lb[lb_idx];
        hmax     = (i_data > pair_q) ? i_data : pair_q;
        vmax     = (hmax > lb_rd) ? hmax : lb_rd;
        last_col = (col == CW'(FW - 1));
        last_row = (row == RW'(FH - 1));
    end

    // Position counters, pair register and registered pooled output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col          <= '0;
            row          <= '0;
            pair_q       <= '0;
            o_en         <= 1'b0;
            o_data       <= '0;
            o_frame_done <= 1'b0;
        end else if (i_flush) begin
            col          <= '0;
            row          <= '0;
            pair_q       <= '0;
            o_en         <= 1'b0;
            o_data       <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_en         <= 1'b0;
            o_data       <= '0;
            o_frame_done <= 1'b0;
            if (i_en) begin
                if (!col[0]) begin
                    pair_q <= i_data;
                end
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (row[0] && col[0]) begin
                    o_en         <= 1'b1;
                    o_data       <= vmax;
                    o_frame_done <= last_row && last_col;
                end
            end
        end
    end

    // Line buffer of even-row pair maxima; always rewritten before being read.
    always_ff @(posedge i_clk) begin
        if (i_en && !i_flush && col[0] && !row[0]) begin
            lb[lb_idx] <= hmax;
        end
    end

endmodule

// File: tb/tb_maxpool2x2.sv
// Directed bench for maxpool2x2 with a 4x4 map and 16-bit data.
// Outputs are logged on the falling edge and compared against expected lists.
`ifndef DW
`define DW 16
`endif

module tb_maxpool2x2;

    logic                  i_clk = 1'b0;
    logic                  i_rst_n = 1'b0;
    logic                  i_en = 1'b0;
    logic signed [`DW-1:0] i_data = '0;
    logic                  i_flush = 1'b0;
    logic                  o_en;
    logic signed [`DW-1:0] o_data;
    logic                  o_frame_done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int idle_bad = 0;

    int got_d[$];
    int got_fd[$];
    int got_cyc[$];
    int exp_d[$];
    int exp_fd[$];
    int exp_cyc[$];

    maxpool2x2 #(.FW(4), .FH(4)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_en         (i_en),
        .i_data       (i_data),
        .i_flush      (i_flush),
        .o_en         (o_en),
        .o_data       (o_data),
        .o_frame_done (o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Log every output strobe; flag idle cycles with stray data.
    always @(negedge i_clk) begin
        if (o_en) begin
            got_d.push_back(int'(o_data));
            got_fd.push_back(int'(o_frame_done));
            got_cyc.push_back(cyc);
        end else if (o_data != '0 || o_frame_done) begin
            idle_bad++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        got_d.delete();
        got_fd.delete();
        got_cyc.delete();
        exp_d.delete();
        exp_fd.delete();
        exp_cyc.delete();
    endtask

    // Drive one pixel for one cycle; optionally queue its expected output.
    task automatic px(input int d, input bit eo, input int ev, input bit efd);
        i_en   = 1'b1;
        i_data = `DW'(d);
        if (eo) begin
            exp_d.push_back(ev);
            exp_fd.push_back(int'(efd));
            exp_cyc.push_back(cyc + 1);
        end
        @(negedge i_clk);
        i_en   = 1'b0;
        i_data = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // Pixels base..base+15; window maxima are the bottom-right pixels.
    task automatic frame(input int base, input int mode);
        for (int k = 0; k < 16; k++) begin
            bit oo;
            oo = ((k / 4) % 2 == 1) && (k % 2 == 1);
            px(base + k, oo, base + k, k == 15);
            if (mode == 1) idle(1);
            if (mode == 1 && k == 6) idle(10);
        end
    endtask

    task automatic compare(input string tag);
        int n;
        idle(3);
        check({tag, "_count"}, got_d.size(), exp_d.size());
        n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
            check($sformatf("%s_done%0d", tag, i), got_fd[i], exp_fd[i]);
            check($sformatf("%s_cyc%0d", tag, i), got_cyc[i], exp_cyc[i]);
        end
        clear_q();
    endtask

    int sp [16] = '{-3, -7, -32768, -1,
                    -1, -9, -2, -5,
                     4,  4, 10, -20,
                     4,  4, 30, -40};
    int se [4]  = '{-1, -1, 4, 30};

    initial begin
        #3;
        check("rst_en", int'(o_en), 0);
        check("rst_data", int'(o_data), 0);
        check("rst_done", int'(o_frame_done), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        idle(2);

        // Reset in the middle of a frame, right while an output is valid.
        for (int k = 0; k < 6; k++) px(k, 1'b0, 0, 1'b0);
        check("pre_rst_en", int'(o_en), 1);
        check("pre_rst_data", int'(o_data), 5);
        #2 i_rst_n = 1'b0;
        #1;
        check("mid_rst_en", int'(o_en), 0);
        check("mid_rst_data", int'(o_data), 0);
        check("mid_rst_done", int'(o_frame_done), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        idle(1);
        clear_q();
        frame(0, 0);
        compare("after_rst");

        frame(0, 0);
        compare("contig");

        frame(0, 1);
        compare("gaps");

        for (int k = 0; k < 16; k++) begin
            bit oo;
            int wi;
            oo = ((k / 4) % 2 == 1) && (k % 2 == 1);
            wi = (k / 8) * 2 + ((k % 4) / 2);
            px(sp[k], oo, se[wi], k == 15);
        end
        compare("signed");

        frame(0, 0);
        frame(100, 0);
        compare("b2b");

        for (int k = 0; k < 5; k++) px(k, 1'b0, 0, 1'b0);
        i_en    = 1'b1;
        i_flush = 1'b1;
        i_data  = `DW'(5);
        @(negedge i_clk);
        i_en    = 1'b0;
        i_flush = 1'b0;
        i_data  = '0;
        check("flush_en", int'(o_en), 0);
        frame(200, 0);
        compare("flush");

        check("idle_zero", idle_bad, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
